// File: rtl/ula_seq.sv
// Sequential ALU. Most opcodes resolve in the accept cycle. MUL and DIV
// iterate one operand bit per cycle before presenting the result.
module ula_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [1:0]       compare_result,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [WIDTH:0]   hi_q, nxt_hi;
  logic [WIDTH-1:0] lo_q, nxt_lo;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q, dbz_q;
  logic [1:0]       cmp_q;
  logic             accept, multi, last;

  // Packs {compare_result, div_by_zero, overflow, result} for the one-cycle opcodes.
  function automatic logic [WIDTH+3:0] alu_single(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0]       op);
    logic [WIDTH:0]     wide;
    logic [2*WIDTH-1:0] shl;
    logic [SW-1:0]      sh;
    logic [WIDTH-1:0]   r;
    logic               o, z;
    logic [1:0]         c;
    wide = '0;
    shl  = '0;
    sh   = b[SW-1:0];
    r    = '0;
    o    = 1'b0;
    z    = 1'b0;
    c    = 2'b00;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        o    = wide[WIDTH];
      end
      OP_SUB: begin
        r = a - b;
        o = (a < b);
      end
      OP_DIV: begin
        r = '1;
        z = 1'b1;
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        shl = {{WIDTH{1'b0}}, a} << sh;
        r   = shl[WIDTH-1:0];
        o   = |shl[2*WIDTH-1:WIDTH];
      end
      OP_SHR: r = a >> sh;
      OP_CMP: c = (a == b) ? 2'b00 : ((a < b) ? 2'b01 : 2'b10);
      default: ;
    endcase
    return {c, z, o, r};
  endfunction

  assign accept = in_valid && in_ready;
  assign multi  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_b != '0));
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = multi ? CALC : DONE;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // MUL: right-shifting shift-add with the multiplier in lo. DIV: restoring, remainder in hi.
  always_comb begin
    nxt_hi  = hi_q;
    nxt_lo  = lo_q;
    mul_sum = '0;
    rem_sh  = '0;
    if (op_q == OP_MUL) begin
      mul_sum = hi_q + (lo_q[0] ? {1'b0, a_q} : '0);
      nxt_hi  = {1'b0, mul_sum[WIDTH:1]};
      nxt_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      rem_sh = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
      if (rem_sh >= {1'b0, b_q}) begin
        nxt_hi = rem_sh - {1'b0, b_q};
        nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh;
        nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= operand_a;
      b_q  <= operand_b;
      op_q <= opcode;
      hi_q <= '0;
      lo_q <= (opcode == OP_MUL) ? operand_b : operand_a;
    end else if (state_q == CALC) begin
      hi_q <= nxt_hi;
      lo_q <= nxt_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      cmp_q    <= 2'b00;
    end else if (accept) begin
      cnt_q <= '0;
      if (!multi) {cmp_q, dbz_q, ovf_q, result_q} <= alu_single(operand_a, operand_b, opcode);
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        result_q <= nxt_lo;
        ovf_q    <= (op_q == OP_MUL) && (|nxt_hi[WIDTH-1:0]);
        dbz_q    <= 1'b0;
        cmp_q    <= 2'b00;
      end
    end
  end

  assign result         = result_q;
  assign overflow       = ovf_q;
  assign div_by_zero    = dbz_q;
  assign compare_result = cmp_q;

endmodule
